// File: rtl/demux1x4_behav_pkg.sv
// Shared constants for the 4-lane byte de-striping demux.
package demux1x4_behav_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef logic [LANE_W-1:0] lane_t;

  // Lane whose byte completes a group.
  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  // Every data register resets to all copies of this bit.
  localparam logic RESET_DATA_BIT = 1'b0;

endpackage

// File: rtl/demux_lane_buffer.sv
// One lane's hold register plus its fill flag.
// clear has priority over load: a byte arriving on a group-closing
// cycle goes straight to the output registers, never into a hold.
module demux_lane_buffer
  import demux1x4_behav_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] data,
  output logic             fill
);

  // Hold register and fill flag: reset, then clear, then load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data <= {WIDTH{RESET_DATA_BIT}};
      fill <= 1'b0;
    end else if (load) begin
      data <= d;
      fill <= 1'b1;
    end
  end

endmodule

// File: rtl/demux1x4_behav.sv
// De-stripes a serial byte stream round-robin into four lanes (lane 0
// first) and presents each completed or flushed group on all lanes at once
// with a one-cycle per-lane valid mask.
//
// Handshake: validin qualifies in for exactly the cycle it is high; there
// is no backpressure, so every valid byte is accepted. validout is a
// one-cycle pulse, bit i qualifying out_i; out0..out3 hold between pulses.
module demux1x4_behav
  import demux1x4_behav_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             validin,
  input  logic             flush,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       validout,
  output logic [1:0]       lane_ptr
);

  logic [LANES-1:0][WIDTH-1:0] hold;
  logic [LANES-1:0]            fill;
  logic [LANES-1:0]            cur_lane;
  logic [LANES-1:0]            mask;
  logic [LANES-1:0]            lane_load;
  logic [LANES-1:0][WIDTH-1:0] lane_byte;
  logic [LANES-1:0][WIDTH-1:0] out_next;
  logic [LANES-1:0][WIDTH-1:0] out_q;
  logic                        complete;
  logic                        group_clear;
  logic                        emit;

  // Decode the current byte's lane, group close and the emitted group.
  // Because lanes fill in order, a completing byte always sees fill=0111,
  // so complete and flush share the same mask-driven output path.
  always_comb begin
    cur_lane           = '0;
    cur_lane[lane_ptr] = validin;
    complete           = validin && (lane_ptr == LAST_LANE);
    mask               = fill | cur_lane;
    group_clear        = complete || flush;
    emit               = complete || (flush && (mask != '0));
    for (int i = 0; i < LANES; i++) begin
      lane_byte[i] = cur_lane[i] ? in : hold[i];
      out_next[i]  = mask[i] ? lane_byte[i] : {WIDTH{RESET_DATA_BIT}};
      lane_load[i] = cur_lane[i] && !group_clear;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk   (clk),
      .reset (reset),
      .load  (lane_load[g]),
      .clear (group_clear),
      .d     (in),
      .data  (hold[g]),
      .fill  (fill[g])
    );
  end

  // Lane pointer and output registers; validout defaults to no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_ptr <= '0;
      out_q    <= {LANES*WIDTH{RESET_DATA_BIT}};
      validout <= '0;
    end else begin
      validout <= '0;
      if (emit) begin
        out_q    <= out_next;
        validout <= mask;
      end
      if (group_clear) begin
        lane_ptr <= '0;
      end else if (validin) begin
        lane_ptr <= lane_ptr + 2'd1;
      end
    end
  end

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];

endmodule

// File: doc/demux1x4_behav.md
Name: demux1x4_behav

Overview:
- Receive-side counterpart of the 4-lane byte-striping mux.
- Takes one serial byte stream with a per-byte valid and de-stripes it round-robin into four parallel lanes (lane 0 first).
- Presents each completed group of four bytes on all lanes at once, with a per-lane valid mask.
- Sits between the serial byte path and the per-lane receive logic of the PHY layer.

Parameters:
- WIDTH, 8, data width per byte/lane.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- in  input  WIDTH  serial data byte.
- validin  input  1  in carries a valid byte this cycle.
- flush  input  1  emit a partially filled group now.
- out0  output  WIDTH  lane 0 byte (first byte of the group).
- out1  output  WIDTH  lane 1 byte.
- out2  output  WIDTH  lane 2 byte.
- out3  output  WIDTH  lane 3 byte.
- validout  output  4  per-lane valid; bit i qualifies out_i; one-cycle pulse.
- lane_ptr  output  2  next lane to be filled (debug/observability).

Behaviour:
- All state updates on rising clk only. No combinational path from inputs to outputs.
- Reset (sync, active-high) clears the following to 0:
  - lane_ptr, and hold registers hold0..hold3;
  - fill mask (4 bits), out0..out3 and validout.
- Reset wins over validin and flush in the same cycle.
- Accept: on validin=1, store the byte in hold[lane_ptr], set fill[lane_ptr], then increment lane_ptr (mod 4, 3 wraps to 0).
- validin=0: nothing changes and lane_ptr holds. Idle gaps between bytes are allowed.
- Group complete, when validin=1 and lane_ptr=3 in cycle N:
  - at edge N+1, out0..out2 load hold0..hold2 and out3 loads in directly;
  - validout=4'b1111 for exactly one cycle;
  - fill clears and lane_ptr returns to 0.
- Latency is 1 clk from the 4th byte to the output pulse.
- Flush (flush=1 in cycle N):
  - Mask M = fill, OR'd with the bit for the current lane when validin=1 (the current byte is included).
  - If M≠0: at N+1, out_i = byte for each set bit of M and 0 for each clear bit; validout=M.
  - After the flush, fill=0 and lane_ptr=0.
  - If M=0: no pulse and validout stays 0; lane_ptr stays 0.
  - flush together with a completing byte (lane_ptr=3, validin=1) behaves exactly like a normal group complete.
- Outputs out0..out3 hold their last value between pulses; validout is 0 on every cycle without a pulse.
- Back-to-back groups are supported: a new byte can be accepted in the same cycle a pulse is emitted, with no bubble needed.
- A mid-group reset discards the partial group; no pulse is emitted.

Decomposition:
- Shared package/include: LANES=4 constant, lane index width=2, reset data value 0.
- One natural sub-module: demux_lane_buffer.
  - Contents: WIDTH-bit hold register plus fill bit, with load enable and clear, synchronous reset.
  - Instantiated four times. The top level holds lane_ptr, flush/complete decode and the output registers.

Test Plan:
- Bytes AA,BB,CC,DD on 4 consecutive cycles with validin=1 -> cycle after DD: out0..3=AA,BB,CC,DD, validout=1111 for 1 cycle, lane_ptr=0.
- Same bytes with validin=0 gaps of 1 to 3 cycles between bytes -> identical outputs; pulse 1 cycle after DD; no pulse before.
- Bytes 11,22, then flush=1 with validin=0 -> out0=11, out1=22, out2=out3=00, validout=0011; then a new group starts at lane 0.
- Bytes 11,22, then flush=1 with validin=1 and in=33 -> out0..2=11,22,33, out3=00, validout=0111.
- Flush with empty buffer -> validout stays 0000, outputs unchanged.
- Reset asserted after 2 of 4 bytes, then 4 new bytes 01..04 -> no pulse from the old bytes; pulse carries 01,02,03,04.
- 8 consecutive valid bytes 00..07 -> two 1111 pulses 4 cycles apart, carrying 00..03 and 04..07.
